logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined bitwise logic unit with valid/ready handshake on both sides.
//  Extends the 2-bit-opcode 8-bit combinational logic unit:
//   - eight operations
//   - accumulator feedback mode (operand B taken from the previous result)
//   - registered zero/parity flags
//  Sits between the operand sequencer and the result writeback path; fully stallable.
// PARAMETERS
//  DATA_WIDTH   8   operand/result width in bits (>=1)
//  OPCODE_SIZE  4   opcode width; bits [2:0] = operation, bit [3] = USE_ACC (fixed at 4)
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            asynchronous reset, active-high
//  a_in         in   DATA_WIDTH   operand A
//  b_in         in   DATA_WIDTH   operand B (ignored when opcode_in[3]=1)
//  opcode_in    in   OPCODE_SIZE  operation select, see BEHAVIOUR
//  valid_in     in   1            upstream offers a_in/b_in/opcode_in
//  ready_out    out  1            block accepts the offer this cycle
//  acc_clr_in   in   1            synchronous clear of accumulator register
//  y_out        out  DATA_WIDTH   result
//  zero_out     out  1            y_out == 0
//  parity_out   out  1            XOR-reduction of y_out
//  valid_out    out  1            y_out/flags valid
//  ready_in     in   1            downstream accepts result
// BEHAVIOUR
//  Opcodes [2:0]:
//   000 OR    001 XOR    010 AND    011 NOT A
//   100 NOR   101 XNOR   110 NAND   111 PASS A
//  opcode[3]=1 (USE_ACC): operand B := acc instead of b_in.
//  Reset (async): s1_valid=0, valid_out=0, y_out=0, zero_out=0, parity_out=0, acc=0;
//   ready_out=1 on first cycle after release.
//  Handshakes:
//   - Transfer in when valid_in && ready_out; transfer out when valid_out && ready_in.
//   - valid_out, once high, stays high with y_out/flags stable until ready_in.
//   - s2_adv  = !valid_out || ready_in
//   - ready_out = !s1_valid || s2_adv  (combinational, no dependency on valid_in)
//  Pipeline:
//   - S1 registers a/b/opcode on input transfer.
//   - S1->S2 move when s1_valid && s2_adv: compute op, load y_out, zero_out, parity_out,
//     and acc := result.
//   - Latency: accepted input -> valid_out 2 cycles; throughput 1/cycle when ready_in=1.
//   - Simultaneous input transfer and S1->S2 move in the same cycle: S1 refills, no bubble.
//  Accumulator:
//   - acc updates only on S1->S2 move, so ops are in order and back-to-back USE_ACC chains
//     see the previous result without hazard.
//   - acc_clr_in and an S1->S2 move in the same cycle: the moving op uses the pre-clear acc;
//     the clear wins and acc=0 afterwards.
//   - acc_clr_in does not touch valid/data in flight.
//  Stall: ready_in=0 with both stages full -> ready_out=0, all registers hold.
//  Reset mid-operation drops in-flight data silently; no partial outputs.
//  All arithmetic is bitwise at DATA_WIDTH; no carries, no width growth.
//  DATA_WIDTH=1 is legal: parity_out==y_out, zero_out==~y_out.
// STRUCTURE
//  Shared package logic_unit_pkg:
//   - opcode localparams OP_OR..OP_PASS, USE_ACC_BIT=3
//   - function lu_eval(op, a, b) returning result
//  Shared with the testbench model.
//  One natural sub-module: logic_unit_core (combinational op decode, DATA_WIDTH parameter),
//   instantiated between S1 and S2.
//  Handshake/acc control stays in the top module.
// TESTING
//  1. Reset, DATA_WIDTH=8:
//     a=8'hF0, b=8'h3C, ops 000..111, ready_in=1
//     -> y_out = FC,CC,30,0F,03,33,CF,F0 two cycles after each accept; one result per cycle.
//  2. Flags: XOR a=8'hA5, b=8'hA5 -> y_out=00, zero_out=1, parity_out=0;
//     OR a=8'h01, b=0 -> zero_out=0, parity_out=1.
//  3. Accumulator chain, acc=0:
//     OR|ACC a=8'h0F -> 0F; XOR|ACC a=8'hFF -> F0; AND|ACC a=8'h3C -> 30.
//     Issued back-to-back, results in order.
//  4. Backpressure: 4 accepted ops, ready_in held 0 for 5 cycles
//     -> ready_out falls after 2 accepts, valid_out/y_out hold first result,
//        no loss or duplication after release.
//  5. acc_clr_in asserted in the same cycle as an OR|ACC move with acc=8'h55, a=0
//     -> y_out=55; next OR|ACC a=0 -> y_out=00.
//  6. Assert rst with both stages full
//     -> valid_out=0, y_out=0 immediately (async); after release the first new op
//        appears after 2 cycles; acc=0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: opcode encodings and the
// bitwise evaluation function used by both the datapath and the bench model.
package logic_unit_pkg;

    // Opcode field layout: bits [2:0] select the operation, bit 3 selects acc as B
    localparam int LU_OPCODE_SIZE = 4;
    localparam int USE_ACC_BIT    = 3;

    // Widest operand the evaluation function handles; callers cast to their width
    localparam int LU_MAX_W = 64;

    localparam logic [2:0] OP_OR   = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOTA = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // Every operation is purely bitwise, so evaluating at the maximum width and
    // truncating gives exactly the narrow result
    function automatic logic [LU_MAX_W-1:0] lu_eval(
        input logic [2:0]          op,
        input logic [LU_MAX_W-1:0] a,
        input logic [LU_MAX_W-1:0] b
    );
        logic [LU_MAX_W-1:0] r;
        case (op)
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_AND:  r = a & b;
            OP_NOTA: r = ~a;
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_NAND: r = ~(a & b);
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational operation decode sitting between the S1 and S2 registers.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    // Zero-extend into the shared evaluator and keep only the low DATA_WIDTH bits
    always_comb begin
        y = DATA_WIDTH'(lu_eval(op, LU_MAX_W'(a), LU_MAX_W'(b)));
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage stallable logic unit: S1 holds the accepted operands, S2 holds the
// registered result and flags. Operand B can be replaced by the accumulator,
// which always tracks the most recent result leaving S1.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int OPCODE_SIZE = LU_OPCODE_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  a_in,
    input  logic [DATA_WIDTH-1:0]  b_in,
    input  logic [OPCODE_SIZE-1:0] opcode_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic                   acc_clr_in,
    output logic [DATA_WIDTH-1:0]  y_out,
    output logic                   zero_out,
    output logic                   parity_out,
    output logic                   valid_out,
    input  logic                   ready_in
);

    logic                   s1_valid;
    logic [DATA_WIDTH-1:0]  s1_a;
    logic [DATA_WIDTH-1:0]  s1_b;
    logic [OPCODE_SIZE-1:0] s1_op;
    logic [DATA_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]  b_eff;
    logic [DATA_WIDTH-1:0]  result;
    logic                   s2_adv;
    logic                   in_xfer;
    logic                   move;

    // Handshake: S2 can take new data when empty or draining; S1 likewise via S2.
    // B is chosen at move time so a back-to-back acc chain sees the fresh result.
    always_comb begin
        s2_adv    = !valid_out || ready_in;
        ready_out = !s1_valid || s2_adv;
        in_xfer   = valid_in && ready_out;
        move      = s1_valid && s2_adv;
        b_eff     = s1_op[USE_ACC_BIT] ? acc : s1_b;
    end

    logic_unit_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .op (s1_op[2:0]),
        .a  (s1_a),
        .b  (b_eff),
        .y  (result)
    );

    // S1 capture: refill on input transfer (even while moving out), empty on move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_a     <= a_in;
                s1_b     <= b_in;
                s1_op    <= opcode_in;
            end else if (move) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // S2 result register: load on move, drop valid once downstream has taken it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out  <= 1'b0;
            y_out      <= '0;
            zero_out   <= 1'b0;
            parity_out <= 1'b0;
        end else begin
            if (move) begin
                valid_out  <= 1'b1;
                y_out      <= result;
                zero_out   <= (result == '0);
                parity_out <= ^result;
            end else if (ready_in) begin
                valid_out  <= 1'b0;
            end
        end
    end

    // Accumulator follows each moving result; a clear overrides that update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (acc_clr_in) begin
            acc <= '0;
        end else if (move) begin
            acc <= result;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: the driver queues hand-computed results
// on every accepted input, the monitor pops and compares on every output transfer.
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [3:0] opcode_in;
    logic       valid_in;
    logic       ready_out;
    logic       acc_clr_in;
    logic [7:0] y_out;
    logic       zero_out;
    logic       parity_out;
    logic       valid_out;
    logic       ready_in;

    typedef struct {
        logic [7:0] y;
        logic       z;
        logic       p;
        string      name;
    } exp_t;

    exp_t       sb_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;

    logic       held;
    logic [7:0] held_y;
    logic       held_z;
    logic       held_p;

    logic_unit_pipe #(
        .DATA_WIDTH (8),
        .OPCODE_SIZE(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_in       (a_in),
        .b_in       (b_in),
        .opcode_in  (opcode_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .acc_clr_in (acc_clr_in),
        .y_out      (y_out),
        .zero_out   (zero_out),
        .parity_out (parity_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in)
    );

    // 10 ns clock; the bench drives at posedge+1 and samples at negedge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure line on mismatch
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one operation (called at posedge+1); queue its expected result on accept
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                  input logic [7:0] exp_y, input bit push, input string name);
        bit   taken;
        exp_t e;
        taken     = 1'b0;
        valid_in  = 1'b1;
        a_in      = a;
        b_in      = b;
        opcode_in = op;
        for (int c = 0; c < 60 && !taken; c++) begin
            #8;
            taken = ready_out;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        if (!taken) begin
            check_output({name, "_accept_timeout"}, 32'd0, 32'd1);
        end else if (push) begin
            e.y    = exp_y;
            e.z    = (exp_y == 8'h00);
            e.p    = ^exp_y;
            e.name = name;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: checks held outputs during stalls and pops the scoreboard on transfers
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check_output("stall_valid_held", {31'd0, valid_out}, 32'd1);
                check_output("stall_y_held", {24'd0, y_out}, {24'd0, held_y});
                check_output("stall_flags_held", {30'd0, zero_out, parity_out}, {30'd0, held_z, held_p});
            end
            if (valid_out && ready_in) begin
                held = 1'b0;
                if (sb_q.size() == 0) begin
                    check_output("unexpected_output", {24'd0, y_out}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_output({e.name, "_y"}, {24'd0, y_out}, {24'd0, e.y});
                    check_output({e.name, "_zero"}, {31'd0, zero_out}, {31'd0, e.z});
                    check_output({e.name, "_parity"}, {31'd0, parity_out}, {31'd0, e.p});
                end
            end else if (valid_out) begin
                held   = 1'b1;
                held_y = y_out;
                held_z = zero_out;
                held_p = parity_out;
            end else begin
                held = 1'b0;
            end
        end
    end

    // Wait (bounded) until every queued result has been seen
    task automatic drain(input string name);
        for (int c = 0; c < 30 && sb_q.size() != 0; c++) @(posedge clk);
        #1;
        check_output({name, "_drained"}, sb_q.size(), 32'd0);
    endtask

    // Directed test sequence
    initial begin
        time t0;
        rst        = 1'b1;
        a_in       = '0;
        b_in       = '0;
        opcode_in  = '0;
        valid_in   = 1'b0;
        acc_clr_in = 1'b0;
        ready_in   = 1'b1;
        held       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check_output("rst_y_out", {24'd0, y_out}, 32'd0);
        check_output("rst_zero_out", {31'd0, zero_out}, 32'd0);
        check_output("rst_parity_out", {31'd0, parity_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("post_rst_ready_out", {31'd0, ready_out}, 32'd1);

        // All eight operations back to back, one accept per cycle
        t0 = $time;
        apply_stimulus(8'hF0, 8'h3C, 4'h0, 8'hFC, 1, "op_or");
        check_output("op_or_latency1", {31'd0, valid_out}, 32'd0);
        apply_stimulus(8'hF0, 8'h3C, 4'h1, 8'hCC, 1, "op_xor");
        check_output("op_or_latency2", {31'd0, valid_out}, 32'd1);
        apply_stimulus(8'hF0, 8'h3C, 4'h2, 8'h30, 1, "op_and");
        apply_stimulus(8'hF0, 8'h3C, 4'h3, 8'h0F, 1, "op_nota");
        apply_stimulus(8'hF0, 8'h3C, 4'h4, 8'h03, 1, "op_nor");
        apply_stimulus(8'hF0, 8'h3C, 4'h5, 8'h33, 1, "op_xnor");
        apply_stimulus(8'hF0, 8'h3C, 4'h6, 8'hCF, 1, "op_nand");
        apply_stimulus(8'hF0, 8'h3C, 4'h7, 8'hF0, 1, "op_pass");
        check_output("throughput_ns", 32'($time - t0), 32'd80);
        drain("ops");

        // Flags
        apply_stimulus(8'hA5, 8'hA5, 4'h1, 8'h00, 1, "flag_zero");
        apply_stimulus(8'h01, 8'h00, 4'h0, 8'h01, 1, "flag_parity");
        drain("flags");

        // Accumulator chain from a cleared accumulator
        acc_clr_in = 1'b1;
        @(posedge clk);
        #1;
        acc_clr_in = 1'b0;
        apply_stimulus(8'h0F, 8'hAA, 4'h8, 8'h0F, 1, "acc_or");
        apply_stimulus(8'hFF, 8'hAA, 4'h9, 8'hF0, 1, "acc_xor");
        apply_stimulus(8'h3C, 8'hAA, 4'hA, 8'h30, 1, "acc_and");
        drain("acc");

        // Backpressure: four ops with the sink stalled for five cycles
        ready_in = 1'b0;
        fork
            begin
                apply_stimulus(8'h11, 8'h22, 4'h0, 8'h33, 1, "bp_or");
                apply_stimulus(8'hFF, 8'h0F, 4'h2, 8'h0F, 1, "bp_and");
                apply_stimulus(8'hAA, 8'h55, 4'h1, 8'hFF, 1, "bp_xor");
                apply_stimulus(8'h12, 8'h00, 4'h3, 8'hED, 1, "bp_nota");
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check_output("bp_ready_out_low", {31'd0, ready_out}, 32'd0);
                check_output("bp_first_held", {24'd0, y_out}, 32'h33);
                ready_in = 1'b1;
            end
        join
        drain("bp");

        // Clear coinciding with an acc move: moving op uses old acc 55
        apply_stimulus(8'h55, 8'h00, 4'h0, 8'h55, 1, "clr_seed");
        drain("clr_seed");
        apply_stimulus(8'h00, 8'hAA, 4'h8, 8'h55, 1, "clr_same_cycle");
        acc_clr_in = 1'b1;
        @(posedge clk);
        #1;
        acc_clr_in = 1'b0;
        apply_stimulus(8'h00, 8'hAA, 4'h8, 8'h00, 1, "clr_after");
        drain("clr");

        // Reset with both stages full: in-flight ops are dropped, acc cleared
        ready_in = 1'b0;
        apply_stimulus(8'hC3, 8'h00, 4'h0, 8'hC3, 0, "rst_fill1");
        apply_stimulus(8'h3C, 8'h00, 4'h0, 8'h3C, 0, "rst_fill2");
        check_output("rst_full_valid", {31'd0, valid_out}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst_valid_out", {31'd0, valid_out}, 32'd0);
        check_output("async_rst_y_out", {24'd0, y_out}, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        ready_in = 1'b1;
        check_output("after_rst_ready_out", {31'd0, ready_out}, 32'd1);
        apply_stimulus(8'h5A, 8'hFF, 4'h9, 8'h5A, 1, "after_rst_acc");
        check_output("after_rst_latency1", {31'd0, valid_out}, 32'd0);
        @(posedge clk);
        #1;
        check_output("after_rst_latency2", {31'd0, valid_out}, 32'd1);
        drain("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
